// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - b_in, processed LSB-first
// in DIGIT-bit groups, one group per clock, with start/busy/valid handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DIGIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int unsigned G    = WIDTH / DIGIT;
    localparam int unsigned CW   = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(G - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic [WIDTH-1:0]  a_q, a_n;
    logic [WIDTH-1:0]  b_q, b_n;
    logic              borrow_q, borrow_n;
    logic [WIDTH-1:0]  part_q, part_n;
    logic              busy_n, valid_n, b_out_n;
    logic [WIDTH-1:0]  diff_n;

    logic [IW-1:0]     base;
    logic [DIGIT-1:0]  a_grp, b_grp;
    logic [DIGIT:0]    sub;

    // Next-state and next-output logic; one DIGIT-bit group per RUN cycle.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        a_n      = a_q;
        b_n      = b_q;
        borrow_n = borrow_q;
        part_n   = part_q;
        busy_n   = busy;
        valid_n  = valid;
        diff_n   = diff;
        b_out_n  = b_out;

        base  = IW'(cnt_q) * IW'(DIGIT);
        a_grp = a_q[base +: DIGIT];
        b_grp = b_q[base +: DIGIT];
        sub   = {1'b0, a_grp} - {1'b0, b_grp} - (DIGIT + 1)'(borrow_q);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = RUN;
                    a_n      = a;
                    b_n      = b;
                    borrow_n = b_in;
                    cnt_n    = '0;
                    part_n   = '0;
                    busy_n   = 1'b1;
                    valid_n  = 1'b0;
                end
            end
            RUN: begin
                part_n[base +: DIGIT] = sub[DIGIT-1:0];
                borrow_n = sub[DIGIT];
                cnt_n    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Publish only the completed result; partials stay internal.
                    diff_n  = part_n;
                    b_out_n = sub[DIGIT];
                    busy_n  = 1'b0;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            part_q   <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            diff     <= '0;
            b_out    <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            a_q      <= a_n;
            b_q      <= b_n;
            borrow_q <= borrow_n;
            part_q   <= part_n;
            busy     <= busy_n;
            valid    <= valid_n;
            diff     <= diff_n;
            b_out    <= b_out_n;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=9, DIGIT=3).
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] a;
    logic [8:0] b;
    logic       b_in;
    logic       busy;
    logic       valid;
    logic [8:0] diff;
    logic       b_out;

    int checks;
    int failures;

    serial_subtractor #(.WIDTH(9), .DIGIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .valid (valid),
        .diff  (diff),
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one accepted edge.
    task automatic launch(input logic [8:0] av, input logic [8:0] bv, input logic bin);
        a     = av;
        b     = bv;
        b_in  = bin;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a     = 9'd0;
        b     = 9'd0;
        b_in  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, valid, diff, b_out} !== 12'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b valid=%b diff=%0d b_out=%b, want all 0",
                     busy, valid, diff, b_out);
        end
    endtask

    task automatic test_basic();
        launch(9'd300, 9'd45, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy cycle %0d: got busy=%b valid=%b, want busy=1 valid=0",
                         i, busy, valid);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || valid !== 1'b1 || diff !== 9'd255 || b_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got busy=%b valid=%b diff=%0d b_out=%b, want 0 1 255 0",
                     busy, valid, diff, b_out);
        end
    endtask

    task automatic test_underflow();
        launch(9'd0, 9'd1, 1'b0);
        tick(); tick(); tick();
        checks++;
        if (valid !== 1'b1 || diff !== 9'd511 || b_out !== 1'b1) begin
            failures++;
            $display("FAIL underflow: got valid=%b diff=%0d b_out=%b, want 1 511 1",
                     valid, diff, b_out);
        end
    endtask

    task automatic test_borrow_in();
        launch(9'd100, 9'd100, 1'b1);
        tick(); tick(); tick();
        checks++;
        if (valid !== 1'b1 || diff !== 9'd511 || b_out !== 1'b1) begin
            failures++;
            $display("FAIL borrow_in_equal: got valid=%b diff=%0d b_out=%b, want 1 511 1",
                     valid, diff, b_out);
        end
        launch(9'd511, 9'd0, 1'b1);
        tick(); tick(); tick();
        checks++;
        if (valid !== 1'b1 || diff !== 9'd510 || b_out !== 1'b0) begin
            failures++;
            $display("FAIL borrow_in_max: got valid=%b diff=%0d b_out=%b, want 1 510 0",
                     valid, diff, b_out);
        end
    endtask

    // Cross-group borrow propagation; table is {a, b, b_in, diff, b_out}.
    task automatic test_vectors();
        logic [8:0] va [5] = '{9'd341, 9'd7,   9'd256, 9'd0,   9'd511};
        logic [8:0] vb [5] = '{9'd170, 9'd8,   9'd255, 9'd0,   9'd511};
        logic       vi [5] = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
        logic [8:0] vd [5] = '{9'd171, 9'd511, 9'd0,   9'd511, 9'd0};
        logic       vo [5] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0};
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i], vi[i]);
            tick(); tick(); tick();
            checks++;
            if (valid !== 1'b1 || diff !== vd[i] || b_out !== vo[i]) begin
                failures++;
                $display("FAIL vector %0d: got valid=%b diff=%0d b_out=%b, want 1 %0d %b",
                         i, valid, diff, b_out, vd[i], vo[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        a     = 9'd200;
        b     = 9'd50;
        b_in  = 1'b0;
        start = 1'b1;
        tick();
        a = 9'd1;
        b = 9'd2;
        b_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) start = 1'b0;
            checks++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                failures++;
                $display("FAIL busy_ignore_start cycle %0d: got busy=%b valid=%b, want 1 0",
                         i, busy, valid);
            end
            a = a + 9'd3;
            tick();
        end
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || diff !== 9'd150 || b_out !== 1'b0) begin
            failures++;
            $display("FAIL busy_result: got valid=%b busy=%b diff=%0d b_out=%b, want 1 0 150 0",
                     valid, busy, diff, b_out);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || diff !== 9'd150) begin
            failures++;
            $display("FAIL done_hold: got valid=%b busy=%b diff=%0d, want 1 0 150",
                     valid, busy, diff);
        end
    endtask

    task automatic test_back_to_back();
        launch(9'd10, 9'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid !== 1'b0 || busy !== 1'b1 || diff !== 9'd150 || b_out !== 1'b0) begin
                failures++;
                $display("FAIL b2b_hold cycle %0d: got valid=%b busy=%b diff=%0d b_out=%b, want 0 1 150 0",
                         i, valid, busy, diff, b_out);
            end
            tick();
        end
        checks++;
        if (valid !== 1'b1 || diff !== 9'd7 || b_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result: got valid=%b diff=%0d b_out=%b, want 1 7 0",
                     valid, diff, b_out);
        end
    endtask

    task automatic test_reset_mid();
        launch(9'd400, 9'd1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, valid, diff, b_out} !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b valid=%b diff=%0d b_out=%b, want all 0",
                     busy, valid, diff, b_out);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", busy, valid);
        end
        reset = 1'b1;
        a     = 9'd9;
        b     = 9'd2;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_over_start: got busy=%b valid=%b, want 0 0", busy, valid);
        end
        launch(9'd5, 9'd5, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_accept: got busy=%b, want 1", busy);
        end
        tick(); tick(); tick();
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || diff !== 9'd0 || b_out !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_result: got valid=%b busy=%b diff=%0d b_out=%b, want 1 0 0 0",
                     valid, busy, diff, b_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_underflow();
        test_borrow_in();
        test_vectors();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
